// File: rtl/arp_pkg.sv
// ============================================================================
// arp_pkg : ARP payload constants, field lengths and decoder state type
// Rev 1.0
// ============================================================================
`default_nettype none

package arp_pkg;

   localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
   localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  ARP_HLEN       = 8'd6;
   localparam logic [7:0]  ARP_PLEN       = 8'd4;
   localparam logic [15:0] ARP_OPER_REQ   = 16'd1;
   localparam logic [15:0] ARP_OPER_REP   = 16'd2;

   // Field lengths in nibbles
   localparam logic [4:0] HDR_NIBBLES = 5'd16;
   localparam logic [4:0] SHA_NIBBLES = 5'd12;
   localparam logic [4:0] SPA_NIBBLES = 5'd8;
   localparam logic [4:0] THA_NIBBLES = 5'd12;
   localparam logic [4:0] TPA_NIBBLES = 5'd8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      HDR      = 3'd1,
      SHA      = 3'd2,
      SPA      = 3'd3,
      THA      = 3'd4,
      TPA      = 3'd5,
      DONE     = 3'd6,
      CRC_WAIT = 3'd7
   } arp_state_t;

endpackage

`default_nettype wire

// File: rtl/arp_decode_nibble_pack.sv
// ============================================================================
// nibble_pack : packs low-then-high receive nibbles into bytes
// Rev 1.0
// ============================================================================
`default_nettype none

module nibble_pack (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       nib_valid,
   input  logic [3:0] nib,
   output logic       byte_valid,
   output logic [7:0] data
);

   logic       phase;
   logic [3:0] low;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= 1'b0;
         low   <= 4'h0;
      end else if (clear) begin
         phase <= 1'b0;
         low   <= 4'h0;
      end else if (nib_valid) begin
         phase <= ~phase;
         if (!phase)
            low <= nib;
      end
   end

   // The byte completes combinationally on its high nibble
   assign byte_valid = nib_valid && phase && !clear;
   assign data       = {nib, low};

endmodule

`default_nettype wire

// File: rtl/arp_decode.sv
// ============================================================================
// arp_decode : parses the 28-byte Ethernet/IPv4 ARP payload from the MAC
//              nibble stream. Optional THA check: define ARP_THA_CHECK_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module arp_decode
   import arp_pkg::*;
#(
   parameter logic [31:0] IP_ADDR  = 32'h0,
   parameter logic [47:0] MAC_ADDR = 48'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  mii_rxd,
   input  logic        mii_rxctl,
   input  logic        arp_decode_valid,
   input  logic        crc_err,
   output logic        arp_valid,
   output logic        arp_drop,
   output logic        arp_is_request,
   output logic [47:0] arp_sha,
   output logic [31:0] arp_spa
);

   arp_state_t  state;
   logic [4:0]  cnt;
   logic        bad;
   logic [55:0] hdr_sr;
   logic        oper_req;
   logic [47:0] sha_sr;
   logic [31:0] spa_sr;
   logic [23:0] tpa_sr;

   logic        w_in_field;
   logic        w_start;
   logic        w_take;
   logic        w_abort;
   logic        w_last;
   logic [4:0]  w_field_len;
   logic        w_field_bad;
   logic        w_byte_valid;
   logic [7:0]  w_byte;
   logic [63:0] w_hdr;
   logic [31:0] w_tpa;
   logic        w_hdr_ok;
   logic        w_tha_ok;

   assign w_in_field = (state == HDR) || (state == SHA) || (state == SPA) ||
                       (state == THA) || (state == TPA);
   assign w_start    = (state == IDLE) && arp_decode_valid && mii_rxctl;
   assign w_take     = w_start || (w_in_field && arp_decode_valid && mii_rxctl);
   assign w_abort    = w_in_field && !w_take;

   nibble_pack u_pack (
      .clk        (clk),
      .rst        (rst),
      .clear      (!w_take),
      .nib_valid  (w_take),
      .nib        (mii_rxd),
      .byte_valid (w_byte_valid),
      .data       (w_byte)
   );

   always_comb begin
      w_field_len = HDR_NIBBLES;
      case (state)
         SHA:     w_field_len = SHA_NIBBLES;
         SPA:     w_field_len = SPA_NIBBLES;
         THA:     w_field_len = THA_NIBBLES;
         TPA:     w_field_len = TPA_NIBBLES;
         default: w_field_len = HDR_NIBBLES;
      endcase
   end

   assign w_last = (cnt == (w_field_len - 5'd1));

   assign w_hdr    = {hdr_sr, w_byte};
   assign w_tpa    = {tpa_sr, w_byte};
   assign w_hdr_ok = (w_hdr[63:48] == ARP_HTYPE_ETH)  &&
                     (w_hdr[47:32] == ARP_PTYPE_IPV4) &&
                     (w_hdr[31:24] == ARP_HLEN)       &&
                     (w_hdr[23:16] == ARP_PLEN)       &&
                     ((w_hdr[15:0] == ARP_OPER_REQ) || (w_hdr[15:0] == ARP_OPER_REP));

`ifdef ARP_THA_CHECK_EN
   logic [39:0] tha_sr;
   logic [47:0] w_tha;

   assign w_tha    = {tha_sr, w_byte};
   // Requests carry an all-zero THA, replies carry our MAC
   assign w_tha_ok = (w_tha == MAC_ADDR) || (w_tha == 48'h0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tha_sr <= 40'h0;
      else if (w_abort)
         tha_sr <= 40'h0;
      else if (state == THA && w_byte_valid)
         tha_sr <= w_tha[39:0];
   end
`else
   logic unused_mac;
   assign unused_mac = ^MAC_ADDR;
   assign w_tha_ok   = 1'b1;
`endif

   always_comb begin
      w_field_bad = 1'b0;
      case (state)
         HDR:     w_field_bad = !w_hdr_ok;
         THA:     w_field_bad = !w_tha_ok;
         TPA:     w_field_bad = (w_tpa != IP_ADDR);
         default: w_field_bad = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= 5'd0;
         bad            <= 1'b0;
         hdr_sr         <= 56'h0;
         oper_req       <= 1'b0;
         sha_sr         <= 48'h0;
         spa_sr         <= 32'h0;
         tpa_sr         <= 24'h0;
         arp_valid      <= 1'b0;
         arp_drop       <= 1'b0;
         arp_is_request <= 1'b0;
         arp_sha        <= 48'h0;
         arp_spa        <= 32'h0;
      end else begin
         arp_valid <= 1'b0;
         arp_drop  <= 1'b0;
         case (state)
            IDLE: begin
               // The start cycle already carries header nibble 0
               if (w_start) begin
                  state <= HDR;
                  cnt   <= 5'd1;
                  bad   <= 1'b0;
               end
            end
            HDR, SHA, SPA, THA, TPA: begin
               if (w_abort) begin
                  arp_drop <= 1'b1;
                  state    <= IDLE;
                  cnt      <= 5'd0;
                  bad      <= 1'b0;
                  hdr_sr   <= 56'h0;
                  oper_req <= 1'b0;
                  sha_sr   <= 48'h0;
                  spa_sr   <= 32'h0;
                  tpa_sr   <= 24'h0;
               end else begin
                  if (w_byte_valid) begin
                     case (state)
                        HDR:     hdr_sr <= w_hdr[55:0];
                        SHA:     sha_sr <= {sha_sr[39:0], w_byte};
                        SPA:     spa_sr <= {spa_sr[23:0], w_byte};
                        TPA:     tpa_sr <= w_tpa[23:0];
                        default: ;
                     endcase
                  end
                  if (w_last) begin
                     cnt <= 5'd0;
                     if (w_field_bad)
                        bad <= 1'b1;
                     case (state)
                        HDR: begin
                           state    <= SHA;
                           oper_req <= (w_hdr[15:0] == ARP_OPER_REQ);
                        end
                        SHA:     state <= SPA;
                        SPA:     state <= THA;
                        THA:     state <= TPA;
                        default: state <= DONE;
                     endcase
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end
            end
            DONE: begin
               if (!mii_rxctl)
                  state <= CRC_WAIT;
            end
            CRC_WAIT: begin
               if (bad || crc_err) begin
                  arp_drop <= 1'b1;
               end else begin
                  arp_valid      <= 1'b1;
                  arp_is_request <= oper_req;
                  arp_sha        <= sha_sr;
                  arp_spa        <= spa_sr;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_arp_decode.sv
// ============================================================================
// tb_arp_decode : table-driven scoreboard bench for arp_decode
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_arp_decode;

   localparam logic [31:0] LOCAL_IP  = 32'hC0A80001;
   localparam logic [47:0] LOCAL_MAC = 48'h020000000099;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  mii_rxd = 4'h0;
   logic        mii_rxctl = 1'b0;
   logic        arp_decode_valid = 1'b0;
   logic        crc_err = 1'b0;
   logic        arp_valid;
   logic        arp_drop;
   logic        arp_is_request;
   logic [47:0] arp_sha;
   logic [31:0] arp_spa;

   arp_decode #(
      .IP_ADDR  (LOCAL_IP),
      .MAC_ADDR (LOCAL_MAC)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .mii_rxd          (mii_rxd),
      .mii_rxctl        (mii_rxctl),
      .arp_decode_valid (arp_decode_valid),
      .crc_err          (crc_err),
      .arp_valid        (arp_valid),
      .arp_drop         (arp_drop),
      .arp_is_request   (arp_is_request),
      .arp_sha          (arp_sha),
      .arp_spa          (arp_spa)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] htype;
      logic [15:0] ptype;
      logic [7:0]  hlen;
      logic [7:0]  plen;
      logic [15:0] oper;
      logic [47:0] sha;
      logic [31:0] spa;
      logic [47:0] tha;
      logic [31:0] tpa;
      bit          crc;
      bit          ok;
   } vec_t;

   typedef struct {
      bit          ok;
      bit          req;
      logic [47:0] sha;
      logic [31:0] spa;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_assert = 0;
   int          n_fail   = 0;
   bit          m_req = 1'b0;
   logic [47:0] m_sha = 48'h0;
   logic [31:0] m_spa = 32'h0;
   vec_t        tbl[11];
   vec_t        base;
   vec_t        v;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs at the pulse: accepted frames update the held values
   task automatic push_exp(input bit ok, input bit req, input logic [47:0] sha, input logic [31:0] spa);
      exp_t e;
      if (ok) begin
         m_req = req;
         m_sha = sha;
         m_spa = spa;
      end
      e.ok  = ok;
      e.req = m_req;
      e.sha = m_sha;
      e.spa = m_spa;
      exp_q.push_back(e);
   endtask

   task automatic push_vec(input vec_t x);
      push_exp(x.ok, x.oper == 16'd1, x.sha, x.spa);
   endtask

   function automatic logic [223:0] make_payload(input vec_t x);
      return {x.htype, x.ptype, x.hlen, x.plen, x.oper, x.sha, x.spa, x.tha, x.tpa};
   endfunction

   task automatic send_nibbles(input vec_t x, input int n);
      logic [223:0] pl;
      logic [7:0]   b;
      pl = make_payload(x);
      mii_rxctl        = 1'b1;
      arp_decode_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         b       = pl[223 - 8*(i/2) -: 8];
         mii_rxd = (i % 2 == 1) ? b[7:4] : b[3:0];
         tick();
      end
   endtask

   task automatic send_frame(input vec_t x, input int pad);
      send_nibbles(x, 56);
      mii_rxd = 4'h0;
      for (int i = 0; i < 2*pad; i++) tick();
      mii_rxctl        = 1'b0;
      arp_decode_valid = 1'b0;
      tick();
      crc_err = x.crc;
      tick();
      crc_err = 1'b0;
      repeat (4) tick();
   endtask

   always @(negedge clk) begin
      if (!rst && (arp_valid || arp_drop)) begin
         if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL unexpected_pulse: got valid=%0b drop=%0b expected none", arp_valid, arp_drop);
         end else begin
            mon_e = exp_q.pop_front();
            check("pulse_kind", {62'h0, arp_valid, arp_drop}, mon_e.ok ? 64'h2 : 64'h1);
            check("arp_sha", {16'h0, arp_sha}, {16'h0, mon_e.sha});
            check("arp_spa", {32'h0, arp_spa}, {32'h0, mon_e.spa});
            check("arp_is_request", {63'h0, arp_is_request}, {63'h0, mon_e.req});
         end
      end
   end

   initial begin
      base.htype = 16'h0001;  base.ptype = 16'h0800;
      base.hlen  = 8'h06;     base.plen  = 8'h04;
      base.oper  = 16'd1;     base.sha   = 48'h020000000001;
      base.spa   = 32'hC0A80002;
      base.tha   = 48'h0;     base.tpa   = 32'hC0A80001;
      base.crc   = 1'b0;      base.ok    = 1'b1;

      for (int i = 0; i < 11; i++) tbl[i] = base;
      tbl[1].crc   = 1'b1;          tbl[1].ok  = 1'b0;
      tbl[2].tpa   = 32'hC0A80009;  tbl[2].ok  = 1'b0;
      tbl[3].htype = 16'h0006;      tbl[3].ok  = 1'b0;
      tbl[4].oper  = 16'd3;         tbl[4].ok  = 1'b0;
      tbl[5].oper  = 16'd2;         tbl[5].sha = 48'h0A1B2C3D4E5F;
      tbl[5].spa   = 32'h0A000001;
      tbl[6].ptype = 16'h0806;      tbl[6].ok  = 1'b0;
      tbl[7].hlen  = 8'h05;         tbl[7].ok  = 1'b0;
      tbl[8].oper  = 16'd2;         tbl[8].tha = 48'h112233445566;
      tbl[8].sha   = 48'hA0B0C0D0E0F0; tbl[8].spa = 32'hC0A80063;
`ifdef ARP_THA_CHECK_EN
      tbl[8].ok    = 1'b0;
`else
      tbl[8].ok    = 1'b1;
`endif
      tbl[9].oper  = 16'd0;         tbl[9].ok  = 1'b0;
      tbl[10].plen = 8'h06;         tbl[10].ok = 1'b0;

      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset_valid", {63'h0, arp_valid}, 64'h0);
      check("reset_drop", {63'h0, arp_drop}, 64'h0);
      check("reset_req", {63'h0, arp_is_request}, 64'h0);
      check("reset_sha", {16'h0, arp_sha}, 64'h0);
      check("reset_spa", {32'h0, arp_spa}, 64'h0);

      for (int i = 0; i < 11; i++) begin
         push_vec(tbl[i]);
         send_frame(tbl[i], 0);
      end

      // Truncation after SPA nibble 3, then a valid reply
      v = base;
      v.sha = 48'h0C0C0C0C0C0C;
      push_exp(1'b0, 1'b0, 48'h0, 32'h0);
      send_nibbles(v, 16 + 12 + 4);
      mii_rxctl        = 1'b0;
      arp_decode_valid = 1'b0;
      tick();
      check("trunc_drop_next_cycle", {63'h0, arp_drop}, 64'h1);
      repeat (3) tick();
      v = base;
      v.oper = 16'd2;
      v.sha  = 48'h5E5E00112233;
      v.spa  = 32'hC0A800FE;
      push_vec(v);
      send_frame(v, 0);

      // 18 padding bytes: single pulse exactly 2 cycles after rxctl falls
      v = base;
      v.sha = 48'h020000000002;
      v.spa = 32'hC0A80003;
      push_vec(v);
      send_nibbles(v, 56);
      mii_rxd = 4'h0;
      for (int i = 0; i < 36; i++) tick();
      mii_rxctl        = 1'b0;
      arp_decode_valid = 1'b0;
      tick();
      check("latency_not_early", {63'h0, arp_valid}, 64'h0);
      tick();
      check("latency_two_cycles", {63'h0, arp_valid}, 64'h1);
      tick();
      check("valid_one_cycle", {63'h0, arp_valid}, 64'h0);
      repeat (4) tick();

      // Reset in the middle of SHA
      send_nibbles(base, 16 + 6);
      rst = 1'b1;
      #1;
      check("midrst_valid", {63'h0, arp_valid}, 64'h0);
      check("midrst_drop", {63'h0, arp_drop}, 64'h0);
      check("midrst_req", {63'h0, arp_is_request}, 64'h0);
      check("midrst_sha", {16'h0, arp_sha}, 64'h0);
      check("midrst_spa", {32'h0, arp_spa}, 64'h0);
      mii_rxctl        = 1'b0;
      arp_decode_valid = 1'b0;
      m_req = 1'b0;
      m_sha = 48'h0;
      m_spa = 32'h0;
      repeat (2) tick();
      rst = 1'b0;
      repeat (2) tick();
      push_vec(base);
      send_frame(base, 2);

      repeat (10) tick();
      check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
